// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Brief    : Iterative reverse double-dabble converter from packed BCD to binary.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [WORK_W-1:0]   work_q;
    logic [WORK_W-1:0]   work_d;
    logic [WORK_W-1:0]   shifted;
    logic [CNT_W-1:0]    cnt_q;
    logic [BIN_W-1:0]    bin_q;
    logic                err_q;
    logic                out_valid_q;
    logic                in_ready_q;
    logic [DIGITS-1:0]   bad_nib;

    assign shifted = work_q >> 1;
    assign work_d[BIN_W-1:0] = shifted[BIN_W-1:0];

    // One shift step: every BCD digit that lands at >= 8 is pulled back by 3.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] dig;
        assign dig                         = shifted[BIN_W+4*g +: 4];
        assign work_d[BIN_W+4*g +: 4]      = (dig >= 4'd8) ? (dig - 4'd3) : dig;
        assign bad_nib[g]                  = (bcd_in[4*g +: 4] > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            bin_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        work_q     <= {bcd_in, {BIN_W{1'b0}}};
                        cnt_q      <= '0;
                        if (|bad_nib) begin
                            state_q <= DONE;
                            err_q   <= 1'b1;
                            bin_q   <= '0;
                        end else begin
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        bin_q   <= work_d[BIN_W-1:0];
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Result is presented one cycle after entering DONE.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign bin_out   = bin_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin
// Brief    : Self-checking bench for bcd_to_bin against a decimal-value model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

    logic        clk;
    logic        rst_n;
    logic [11:0] bcd_in;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  bin_out;
    logic        err;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_legal(input logic [11:0] b);
        return (b[3:0] <= 9) && (b[7:4] <= 9) && (b[11:8] <= 9);
    endfunction

    function automatic int model_val(input logic [11:0] b);
        return 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Starts at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    task automatic do_op(input logic [11:0] bcd, input int hold, input bit noisy);
        int cyc;
        bit legal;
        bit done;
        int exp;
        legal = model_legal(bcd);
        exp   = legal ? model_val(bcd) : 0;
        check("in_ready_idle", in_ready, 1);
        bcd_in    = bcd;
        in_valid  = 1'b1;
        out_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            if (noisy) begin
                in_valid  = 1'($urandom_range(0, 1));
                bcd_in    = 12'($urandom);
                out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", cyc, legal ? 11 : 1);
        check("bin_out", bin_out, exp);
        check("err", err, !legal);
        check("in_ready_busy", in_ready, 0);
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_bin", bin_out, exp);
            check("hold_in_ready", in_ready, 0);
        end
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            out_ready = (noisy && k < 63) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (out_ready) done = 1'b1;
            else begin
                check("bp_valid", out_valid, 1);
                check("bp_bin", bin_out, exp);
            end
        end
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    initial begin
        logic [11:0] b;
        rst_n     = 1'b0;
        bcd_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_bin_out", bin_out, 0);
        rst_n = 1'b1;

        do_op(12'h018, 0, 1'b0);
        do_op(12'h999, 0, 1'b0);
        do_op(12'h000, 0, 1'b0);
        do_op(12'h0A5, 0, 1'b0);
        do_op(12'hB00, 0, 1'b0);
        do_op(12'h00F, 0, 1'b0);
        do_op(12'h123, 20, 1'b0);

        // Abort a conversion mid-flight with reset.
        bcd_in   = 12'h456;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_err", err, 0);
        check("abort_bin_out", bin_out, 0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            check("abort_no_result", out_valid, 0);
        end
        do_op(12'h456, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            do_op(b, 0, 1'b1);
        end

        for (int i = 0; i < 20; i++) begin
            b = 12'($urandom);
            for (int t = 0; t < 50 && model_legal(b); t++) b = 12'($urandom);
            do_op(b, 0, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
